instr_encoder_loader: RTL and testbench
=======================================

// Module: instr_encoder_loader
// PURPOSE
//  Encoder-side counterpart of the main control decoder: accepts symbolic instruction commands
//  (kind + register/immediate fields) over a valid/ready stream, encodes each into a 32-bit MIPS
//  word and writes it sequentially into instruction memory. Used by the boot/program-load path
//  and by test benches to build programs for the single-cycle core.
// PARAMETERS
//  ADDR_W     8    instruction-memory word-address width
//  DEPTH      256  number of writable words, DEPTH <= 2**ADDR_W
//  BASE_ADDR  0    first word address written after start
// PORTS
//  clk           in   1       single clock, rising edge
//  rst_n         in   1       asynchronous, active-low reset
//  start         in   1       begin a load session (honoured in IDLE/FULL only)
//  abort         in   1       synchronous return to IDLE, pending write dropped
//  cmd_valid     in   1       command present
//  cmd_ready     out  1       command accepted when valid&ready
//  cmd_kind      in   4       instruction kind (encoding table below)
//  cmd_rs        in   5       rs field
//  cmd_rt        in   5       rt field
//  cmd_rd        in   5       rd field (R-type only)
//  cmd_shamt     in   5       shamt (R-type only)
//  cmd_funct     in   6       funct (R-type only)
//  cmd_imm       in   16      immediate/offset (I-type)
//  cmd_target    in   26      jump target (J/JAL)
//  cmd_last      in   1       final command of session
//  im_we         out  1       instruction-memory write strobe, one cycle per word
//  im_addr       out  ADDR_W  word address
//  im_wdata      out  32      encoded instruction
//  words_written out  ADDR_W+1 words written this session
//  done          out  1       one-cycle pulse at end of session
//  err_illegal   out  1       sticky: illegal kind seen this session
//  err_full      out  1       sticky: DEPTH exhausted before cmd_last
// BEHAVIOUR
//  - Reset: state=IDLE; cmd_ready, im_we, done, err_* = 0; im_addr, im_wdata, words_written = 0.
//  - Kinds: 0 R {000000,rs,rt,rd,shamt,funct}; 1 ADDI 001000; 2 ANDI 001100; 3 ORI 001101;
//    4 XORI 001110; 5 LW 100011; 6 SW 101011; 7 BEQ 000100; 8 BNE 000101 -> {op,rs,rt,imm};
//    9 J 000010, 10 JAL 000011 -> {op,target}; 11..15 illegal.
//  - FSM IDLE/RUN/FULL/DONE. IDLE: cmd_ready=0; start -> RUN, ptr<=BASE_ADDR, count/err_* cleared.
//  - RUN: cmd_ready=1. Accepted legal command -> next cycle im_we=1, im_addr=ptr, im_wdata=word
//    (latency 1, registered outputs); ptr++, words_written++. Back-to-back accepts: 1 word/cycle.
//  - Illegal kind: consumed, no write, ptr unchanged, err_illegal<=1.
//  - Accepted cmd_last (legal or illegal) -> DONE; DONE lasts 1 cycle with done=1, then IDLE.
//  - Write that brings words_written to DEPTH without cmd_last -> FULL: cmd_ready=0, err_full<=1;
//    start in FULL restarts a session (-> RUN). Last command filling DEPTH exactly -> DONE, no error.
//  - start while RUN ignored. abort in any state -> IDLE next cycle, im_we suppressed that cycle,
//    err_*/words_written held for inspection. abort has priority over start and accept.
//  - rst_n low mid-session: everything returns to reset values immediately; nothing written after.
//  - im_addr never exceeds BASE_ADDR+DEPTH-1; no wrap-around.
// STRUCTURE
//  - mips_isa_pkg: kind codes, opcode localparams (OP_RTYPE, OP_ADDI, ... OP_JAL), state enum.
//    Opcode constants are shared with the control decoder to keep both ends consistent.
//  - Sub-module mips_word_encoder: combinational kind+fields -> {word[31:0], illegal}; this block
//    adds FSM, pointer/count, handshake and output registers.
// TESTING
//  - start; R rs=1 rt=2 rd=3 shamt=0 funct=0x20 -> im_we @addr0, im_wdata=0x00221820.
//  - Back-to-back ADDI rs=1 rt=2 imm=5, SW rs=29 rt=31 imm=4, BNE rs=4 rt=5 imm=0xFFFE(last) ->
//    0x20220005@0, 0xAFBF0004@1, 0x1485FFFE@2 on consecutive cycles, done pulse, words_written=3.
//  - J target=0x10, kind 12, JAL target=0x3FFFFFF(last) -> 0x08000010@0, 0x0FFFFFFF@1,
//    err_illegal=1, words_written=2.
//  - DEPTH=4: five commands no last -> writes @0..3, FULL, cmd_ready=0, err_full=1; start -> RUN @0.
//  - cmd_valid held with random stalls; abort mid-stream -> no write after abort; rst_n pulse
//    during RUN -> all outputs 0 asynchronously.
//  - Round trip: every legal kind encoded, then decoded by main control decoder; control fields match.

Source files
------------

// File: rtl/mips_isa_pkg.sv
// MIPS ISA constants shared by the instruction encoder and the control decoder.
// Kind codes, primary opcodes and the loader state encoding.
package mips_isa_pkg;

  localparam logic [3:0] K_R    = 4'd0;
  localparam logic [3:0] K_ADDI = 4'd1;
  localparam logic [3:0] K_ANDI = 4'd2;
  localparam logic [3:0] K_ORI  = 4'd3;
  localparam logic [3:0] K_XORI = 4'd4;
  localparam logic [3:0] K_LW   = 4'd5;
  localparam logic [3:0] K_SW   = 4'd6;
  localparam logic [3:0] K_BEQ  = 4'd7;
  localparam logic [3:0] K_BNE  = 4'd8;
  localparam logic [3:0] K_J    = 4'd9;
  localparam logic [3:0] K_JAL  = 4'd10;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FULL,
    S_DONE
  } state_e;

endpackage

// File: rtl/mips_word_encoder.sv
// Combinational encoder: instruction kind plus fields -> 32-bit MIPS word.
// Kinds outside the table produce a zero word and raise illegal.
module mips_word_encoder
  import mips_isa_pkg::*;
(
  input  logic [3:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    unique case (1'b1)
      (kind == K_R):    word = {OP_RTYPE, rs, rt, rd, shamt, funct};
      (kind == K_ADDI): word = {OP_ADDI, rs, rt, imm};
      (kind == K_ANDI): word = {OP_ANDI, rs, rt, imm};
      (kind == K_ORI):  word = {OP_ORI, rs, rt, imm};
      (kind == K_XORI): word = {OP_XORI, rs, rt, imm};
      (kind == K_LW):   word = {OP_LW, rs, rt, imm};
      (kind == K_SW):   word = {OP_SW, rs, rt, imm};
      (kind == K_BEQ):  word = {OP_BEQ, rs, rt, imm};
      (kind == K_BNE):  word = {OP_BNE, rs, rt, imm};
      (kind == K_J):    word = {OP_J, target};
      (kind == K_JAL):  word = {OP_JAL, target};
      default:          illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Streams symbolic commands into instruction memory as encoded MIPS words.
// One word per accepted legal command, written with one cycle of latency.
module instr_encoder_loader
  import mips_isa_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_kind,
  input  logic [4:0]        cmd_rs,
  input  logic [4:0]        cmd_rt,
  input  logic [4:0]        cmd_rd,
  input  logic [4:0]        cmd_shamt,
  input  logic [5:0]        cmd_funct,
  input  logic [15:0]       cmd_imm,
  input  logic [25:0]       cmd_target,
  input  logic              cmd_last,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic [ADDR_W:0]   words_written,
  output logic              done,
  output logic              err_illegal,
  output logic              err_full
);

  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ONE_P = ADDR_W'(1);
  localparam logic [ADDR_W:0]   ONE_C = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   FILL  = (ADDR_W+1)'(DEPTH);

  state_e            state;
  state_e            state_nx;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   count;
  logic              we_q;
  logic [31:0]       word;
  logic              illegal;
  logic              accept;
  logic              wr;
  logic              sess;
  logic              at_fill;

  mips_word_encoder u_enc (
    .kind    (cmd_kind),
    .rs      (cmd_rs),
    .rt      (cmd_rt),
    .rd      (cmd_rd),
    .shamt   (cmd_shamt),
    .funct   (cmd_funct),
    .imm     (cmd_imm),
    .target  (cmd_target),
    .word    (word),
    .illegal (illegal)
  );

  // abort blocks the handshake so nothing is consumed on that cycle
  assign cmd_ready = (state == S_RUN) && !abort;
  assign accept    = cmd_valid && cmd_ready;
  assign wr        = accept && !illegal;
  assign at_fill   = (count + ONE_C) == FILL;
  assign sess      = start && !abort &&
                     ((state == S_IDLE) || (state == S_FULL));

  assign im_we         = we_q && !abort;
  assign done          = (state == S_DONE);
  assign words_written = count;

  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE, S_FULL: if (start) state_nx = S_RUN;
        S_RUN: begin
          if (accept && cmd_last)      state_nx = S_DONE;
          else if (wr && at_fill)      state_nx = S_FULL;
        end
        S_DONE:                        state_nx = S_IDLE;
        default:                       state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q        <= 1'b0;
      im_addr     <= '0;
      im_wdata    <= '0;
      ptr         <= BASE;
      count       <= '0;
      err_illegal <= 1'b0;
      err_full    <= 1'b0;
    end else begin
      we_q <= wr;
      if (sess) begin
        ptr         <= BASE;
        count       <= '0;
        err_illegal <= 1'b0;
        err_full    <= 1'b0;
      end
      if (wr) begin
        im_addr  <= ptr;
        im_wdata <= word;
        ptr      <= ptr + ONE_P;
        count    <= count + ONE_C;
      end
      if (accept && illegal)
        err_illegal <= 1'b1;
      if (wr && at_fill && !cmd_last)
        err_full <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader (full-size and DEPTH=4 instances).
// Randomized commands are compared against an arithmetic encoding model.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        start_s = 1'b0;
  logic        abort = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [3:0]  cmd_kind = '0;
  logic [4:0]  cmd_rs = '0;
  logic [4:0]  cmd_rt = '0;
  logic [4:0]  cmd_rd = '0;
  logic [4:0]  cmd_shamt = '0;
  logic [5:0]  cmd_funct = '0;
  logic [15:0] cmd_imm = '0;
  logic [25:0] cmd_target = '0;
  logic        cmd_last = 1'b0;

  logic        rdy, we, dn, eill, efull;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [8:0]  ww;
  logic        rdy_s, we_s, dn_s, eill_s, efull_s;
  logic [7:0]  addr_s;
  logic [31:0] wdata_s;
  logic [8:0]  ww_s;

  instr_encoder_loader u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cmd_valid(cmd_valid), .cmd_ready(rdy), .cmd_kind(cmd_kind),
    .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
    .cmd_shamt(cmd_shamt), .cmd_funct(cmd_funct), .cmd_imm(cmd_imm),
    .cmd_target(cmd_target), .cmd_last(cmd_last),
    .im_we(we), .im_addr(addr), .im_wdata(wdata),
    .words_written(ww), .done(dn), .err_illegal(eill), .err_full(efull)
  );

  instr_encoder_loader #(.ADDR_W(8), .DEPTH(4), .BASE_ADDR(0)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start_s), .abort(abort),
    .cmd_valid(cmd_valid), .cmd_ready(rdy_s), .cmd_kind(cmd_kind),
    .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
    .cmd_shamt(cmd_shamt), .cmd_funct(cmd_funct), .cmd_imm(cmd_imm),
    .cmd_target(cmd_target), .cmd_last(cmd_last),
    .im_we(we_s), .im_addr(addr_s), .im_wdata(wdata_s),
    .words_written(ww_s), .done(dn_s), .err_illegal(eill_s),
    .err_full(efull_s)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cnt_s = 0;
  int          wq_addr[$];
  logic [31:0] wq_data[$];
  int          wq_cyc[$];
  int          sq_addr[$];
  logic [31:0] sq_data[$];

  logic [5:0] opc_tab [0:10] = '{6'd0, 6'd8, 6'd12, 6'd13, 6'd14,
                                 6'd35, 6'd43, 6'd4, 6'd5, 6'd2, 6'd3};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (we) begin
      wq_addr.push_back(int'(addr));
      wq_data.push_back(wdata);
      wq_cyc.push_back(cyc);
    end
    if (dn) done_cnt++;
    if (we_s) begin
      sq_addr.push_back(int'(addr_s));
      sq_data.push_back(wdata_s);
    end
    if (dn_s) done_cnt_s++;
  end

  function automatic logic [31:0] ref_word(input int k,
    input logic [31:0] rs, rt, rd, sh, fn, imm, tgt);
    logic [31:0] op;
    op = {26'd0, opc_tab[k]};
    if (k == 0) return (rs << 21) | (rt << 16) | (rd << 11) | (sh << 6) | fn;
    if (k >= 9) return (op << 26) | tgt;
    return (op << 26) | (rs << 21) | (rt << 16) | imm;
  endfunction

  // control-decoder view: primary opcode back to an instruction kind
  function automatic int decode_kind(input logic [31:0] w);
    for (int k = 0; k <= 10; k++)
      if (opc_tab[k] == w[31:26]) return k;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int k, rs, rt, rd, sh, fn, imm, tgt,
                         input bit last);
    cmd_kind = 4'(k);
    cmd_rs = 5'(rs);
    cmd_rt = 5'(rt);
    cmd_rd = 5'(rd);
    cmd_shamt = 5'(sh);
    cmd_funct = 6'(fn);
    cmd_imm = 16'(imm);
    cmd_target = 26'(tgt);
    cmd_last = last;
  endtask

  task automatic send(input bit sm, input int limit, output bit acc);
    acc = 1'b0;
    cmd_valid = 1'b1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (sm ? rdy_s : rdy) begin
        acc = 1'b1;
        tick();
        break;
      end
      tick();
    end
  endtask

  task automatic pulse_start(input bit sm);
    if (sm) start_s = 1'b1;
    else    start = 1'b1;
    tick();
    start = 1'b0;
    start_s = 1'b0;
  endtask

  task automatic go_idle();
    cmd_valid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
  endtask

  task automatic clear_q();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
    sq_addr.delete();
    sq_data.delete();
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if ({rdy, we, dn, eill, efull, addr, wdata, ww} !== '0) begin
      failures++;
      $display("FAIL reset_hold got rdy=%b we=%b done=%b addr=%h wdata=%h ww=%0d exp all 0",
               rdy, we, dn, addr, wdata, ww);
    end
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    checks++;
    if ({rdy, we, dn, eill, efull, addr, wdata, ww} !== '0) begin
      failures++;
      $display("FAIL reset_idle got rdy=%b we=%b done=%b addr=%h wdata=%h ww=%0d exp all 0",
               rdy, we, dn, addr, wdata, ww);
    end
    tick();
  endtask

  task automatic test_rtype();
    bit acc;
    clear_q();
    pulse_start(0);
    set_cmd(0, 1, 2, 3, 0, 'h20, 0, 0, 0);
    send(0, 20, acc);
    cmd_valid = 1'b0;
    repeat (3) tick();
    checks++;
    if (!acc || wq_data.size() != 1 || wq_data[0] !== 32'h00221820
        || wq_addr[0] != 0) begin
      failures++;
      $display("FAIL rtype_word got n=%0d data=%h addr=%0d exp n=1 00221820@0",
               wq_data.size(), wq_data[0], wq_addr[0]);
    end
    checks++;
    if (ww !== 9'd1) begin
      failures++;
      $display("FAIL rtype_count got=%0d exp=1", ww);
    end
    pulse_start(0);
    set_cmd(0, 4, 5, 6, 2, 'h22, 0, 0, 0);
    send(0, 20, acc);
    cmd_valid = 1'b0;
    repeat (3) tick();
    checks++;
    if (wq_addr.size() != 2 || wq_addr[1] != 1 || ww !== 9'd2) begin
      failures++;
      $display("FAIL start_in_run got n=%0d addr=%0d ww=%0d exp n=2 addr=1 ww=2",
               wq_addr.size(), wq_addr[1], ww);
    end
    go_idle();
  endtask

  task automatic test_back_to_back();
    bit a0, a1, a2;
    int d0;
    clear_q();
    d0 = done_cnt;
    pulse_start(0);
    set_cmd(1, 1, 2, 0, 0, 0, 5, 0, 0);
    send(0, 20, a0);
    set_cmd(6, 29, 31, 0, 0, 0, 4, 0, 0);
    send(0, 20, a1);
    set_cmd(8, 4, 5, 0, 0, 0, 'hFFFE, 0, 1);
    send(0, 20, a2);
    cmd_valid = 1'b0;
    repeat (3) tick();
    checks++;
    if (!(a0 && a1 && a2) || wq_data.size() != 3) begin
      failures++;
      $display("FAIL b2b_count got n=%0d acc=%b%b%b exp n=3 acc=111",
               wq_data.size(), a0, a1, a2);
    end
    checks++;
    if (wq_data[0] !== 32'h20220005 || wq_data[1] !== 32'hAFBF0004
        || wq_data[2] !== 32'h1485FFFE) begin
      failures++;
      $display("FAIL b2b_data got %h %h %h exp 20220005 afbf0004 1485fffe",
               wq_data[0], wq_data[1], wq_data[2]);
    end
    checks++;
    if (wq_addr[0] != 0 || wq_addr[1] != 1 || wq_addr[2] != 2
        || wq_cyc[1] != wq_cyc[0] + 1 || wq_cyc[2] != wq_cyc[1] + 1) begin
      failures++;
      $display("FAIL b2b_timing got addr=%0d,%0d,%0d cyc=%0d,%0d,%0d exp 0,1,2 consecutive",
               wq_addr[0], wq_addr[1], wq_addr[2], wq_cyc[0], wq_cyc[1], wq_cyc[2]);
    end
    checks++;
    if (done_cnt - d0 != 1 || ww !== 9'd3 || rdy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_done got pulses=%0d ww=%0d rdy=%b exp 1 3 0",
               done_cnt - d0, ww, rdy);
    end
  endtask

  task automatic test_jump_illegal();
    bit a0, a1, a2;
    clear_q();
    pulse_start(0);
    set_cmd(9, 0, 0, 0, 0, 0, 0, 'h10, 0);
    send(0, 20, a0);
    set_cmd(12, 3, 3, 3, 3, 3, 3, 3, 0);
    send(0, 20, a1);
    set_cmd(10, 0, 0, 0, 0, 0, 0, 'h3FFFFFF, 1);
    send(0, 20, a2);
    cmd_valid = 1'b0;
    repeat (3) tick();
    checks++;
    if (wq_data.size() != 2 || wq_data[0] !== 32'h08000010
        || wq_data[1] !== 32'h0FFFFFFF || wq_addr[1] != 1) begin
      failures++;
      $display("FAIL jump_words got n=%0d %h %h@%0d exp 2 08000010 0fffffff@1",
               wq_data.size(), wq_data[0], wq_data[1], wq_addr[1]);
    end
    checks++;
    if (eill !== 1'b1 || ww !== 9'd2 || efull !== 1'b0) begin
      failures++;
      $display("FAIL illegal_flag got eill=%b ww=%0d efull=%b exp 1 2 0",
               eill, ww, efull);
    end
  endtask

  task automatic test_full();
    bit acc;
    int d0;
    clear_q();
    d0 = done_cnt_s;
    pulse_start(1);
    for (int i = 0; i < 4; i++) begin
      set_cmd(1, i, i + 1, 0, 0, 0, i, 0, 0);
      send(1, 20, acc);
      checks++;
      if (!acc) begin
        failures++;
        $display("FAIL full_accept got=0 exp=1 idx=%0d", i);
      end
    end
    set_cmd(2, 7, 7, 0, 0, 0, 7, 0, 0);
    send(1, 5, acc);
    cmd_valid = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (acc || sq_addr.size() != 4 || sq_addr[0] != 0 || sq_addr[3] != 3) begin
      failures++;
      $display("FAIL full_writes got acc5=%b n=%0d first=%0d last=%0d exp 0 4 0 3",
               acc, sq_addr.size(), sq_addr[0], sq_addr[3]);
    end
    checks++;
    if (rdy_s !== 1'b0 || efull_s !== 1'b1 || ww_s !== 9'd4
        || done_cnt_s != d0) begin
      failures++;
      $display("FAIL full_state got rdy=%b efull=%b ww=%0d done=%0d exp 0 1 4 0",
               rdy_s, efull_s, ww_s, done_cnt_s - d0);
    end
    tick();
    pulse_start(1);
    set_cmd(3, 1, 1, 0, 0, 0, 1, 0, 0);
    send(1, 20, acc);
    cmd_valid = 1'b0;
    repeat (2) tick();
    checks++;
    if (!acc || sq_addr.size() != 5 || sq_addr[4] != 0
        || efull_s !== 1'b0 || ww_s !== 9'd1) begin
      failures++;
      $display("FAIL full_restart got n=%0d addr=%0d efull=%b ww=%0d exp 5 0 0 1",
               sq_addr.size(), sq_addr[4], efull_s, ww_s);
    end
    for (int i = 0; i < 3; i++) begin
      set_cmd(4, i, i, 0, 0, 0, i, 0, i == 2);
      send(1, 20, acc);
    end
    cmd_valid = 1'b0;
    repeat (3) tick();
    checks++;
    if (efull_s !== 1'b0 || ww_s !== 9'd4 || done_cnt_s != d0 + 1
        || sq_addr[7] != 3) begin
      failures++;
      $display("FAIL exact_fill got efull=%b ww=%0d done=%0d addr=%0d exp 0 4 1 3",
               efull_s, ww_s, done_cnt_s - d0, sq_addr[7]);
    end
  endtask

  task automatic test_abort();
    bit acc;
    logic [8:0] hold;
    clear_q();
    pulse_start(0);
    set_cmd(1, 1, 1, 0, 0, 0, 1, 0, 0);
    send(0, 20, acc);
    set_cmd(2, 2, 2, 0, 0, 0, 2, 0, 0);
    send(0, 20, acc);
    set_cmd(3, 3, 3, 0, 0, 0, 3, 0, 0);
    abort = 1'b1;
    @(negedge clk);
    hold = ww;
    checks++;
    if (we !== 1'b0 || rdy !== 1'b0) begin
      failures++;
      $display("FAIL abort_gate got we=%b rdy=%b exp 0 0", we, rdy);
    end
    tick();
    abort = 1'b0;
    repeat (4) tick();
    checks++;
    if (wq_data.size() != 1 || ww !== hold || hold !== 9'd2 || rdy !== 1'b0) begin
      failures++;
      $display("FAIL abort_drop got n=%0d ww=%0d hold=%0d rdy=%b exp 1 2 2 0",
               wq_data.size(), ww, hold, rdy);
    end
    cmd_valid = 1'b0;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    checks++;
    if (rdy !== 1'b0) begin
      failures++;
      $display("FAIL abort_prio got rdy=%b exp 0", rdy);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bit acc;
    clear_q();
    pulse_start(0);
    set_cmd(5, 8, 9, 0, 0, 0, 16, 0, 0);
    send(0, 20, acc);
    set_cmd(7, 8, 9, 0, 0, 0, 32, 0, 0);
    send(0, 20, acc);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({rdy, we, dn, eill, efull, addr, wdata, ww} !== '0) begin
      failures++;
      $display("FAIL reset_async got rdy=%b we=%b addr=%h wdata=%h ww=%0d exp all 0",
               rdy, we, addr, wdata, ww);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    cmd_valid = 1'b0;
    checks++;
    if (wq_data.size() != 1 || ww !== 9'd0 || rdy !== 1'b0) begin
      failures++;
      $display("FAIL reset_nowrite got n=%0d ww=%0d rdy=%b exp 1 0 0",
               wq_data.size(), ww, rdy);
    end
  endtask

  task automatic test_random();
    bit acc;
    int n, k, cnt, d0;
    bit ill;
    logic [31:0] rs, rt, rd, sh, fn, imm, tgt;
    logic [31:0] exp_w[$];
    int exp_k[$];
    for (int s = 0; s < 4; s++) begin
      clear_q();
      exp_w.delete();
      exp_k.delete();
      cnt = 0;
      ill = 1'b0;
      d0 = done_cnt;
      n = $urandom_range(30, 5);
      pulse_start(0);
      for (int i = 0; i < n; i++) begin
        cmd_valid = 1'b0;
        repeat ($urandom_range(2, 0)) tick();
        k = ($urandom_range(9, 0) == 0) ? $urandom_range(15, 11)
                                       : $urandom_range(10, 0);
        rs = $urandom_range(31, 0);
        rt = $urandom_range(31, 0);
        rd = $urandom_range(31, 0);
        sh = $urandom_range(31, 0);
        fn = $urandom_range(63, 0);
        imm = $urandom_range(65535, 0);
        tgt = $urandom & 32'h03FF_FFFF;
        set_cmd(k, rs, rt, rd, sh, fn, imm, tgt, i == n - 1);
        send(0, 20, acc);
        checks++;
        if (!acc) begin
          failures++;
          $display("FAIL rand_accept got=0 exp=1 sess=%0d idx=%0d", s, i);
        end
        if (k <= 10) begin
          exp_w.push_back(ref_word(k, rs, rt, rd, sh, fn, imm, tgt));
          exp_k.push_back(k);
          cnt++;
        end else begin
          ill = 1'b1;
        end
      end
      cmd_valid = 1'b0;
      repeat (3) tick();
      checks++;
      if (wq_data.size() != cnt || ww !== 9'(cnt) || eill !== ill
          || done_cnt - d0 != 1) begin
        failures++;
        $display("FAIL rand_session got n=%0d ww=%0d eill=%b done=%0d exp %0d %0d %b 1",
                 wq_data.size(), ww, eill, done_cnt - d0, cnt, cnt, ill);
      end
      for (int j = 0; j < cnt && j < wq_data.size(); j++) begin
        checks++;
        if (wq_data[j] !== exp_w[j] || wq_addr[j] != j) begin
          failures++;
          $display("FAIL rand_word got %h@%0d exp %h@%0d",
                   wq_data[j], wq_addr[j], exp_w[j], j);
        end
        checks++;
        if (decode_kind(wq_data[j]) != exp_k[j]) begin
          failures++;
          $display("FAIL round_trip got kind=%0d exp=%0d",
                   decode_kind(wq_data[j]), exp_k[j]);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rtype();
    test_back_to_back();
    test_jump_illegal();
    test_full();
    test_abort();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
